sram_port_arbiter: RTL and testbench

//   Shares the single read/write port (port 0) of one sky130 OpenRAM macro between
//   two requesters: the caravel Wishbone slave bus and the test-engine request port.
//   It arbitrates round-robin and drives registered csb0/web0/wmask0/addr0/din0.
//   It captures dout0 and returns it with a Wishbone ack or a test-port rvalid.
//   It sits in user_project_wrapper between the bus/test logic and the SRAM macro.

---
 rtl/sram_port_arbiter.sv | 86 ++++++++
 tb/tb_sram_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one OpenRAM RW port between Wishbone and a test port
module sram_port_arbiter #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic                tst_req_i,
    input  logic                tst_we_i,
    input  logic [DATA_W/8-1:0] tst_wmask_i,
    input  logic [ADDR_W-1:0]   tst_addr_i,
    input  logic [DATA_W-1:0]   tst_wdata_i,
    output logic                tst_gnt_o,
    output logic                tst_rvalid_o,
    output logic [DATA_W-1:0]   tst_rdata_o,
    output logic                sram_csb0_o,
    output logic                sram_web0_o,
    output logic [DATA_W/8-1:0] sram_wmask0_o,
    output logic [ADDR_W-1:0]   sram_addr0_o,
    output logic [DATA_W-1:0]   sram_din0_o,
    input  logic [DATA_W-1:0]   sram_dout0_i,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, RESP} state_t;
    state_t state, state_nx;
    logic wb_hit, start, grant_tst, owner_tst, last_tst, we_q, ack_q;
    logic [31:0] wb_rdata;
    assign wb_hit    = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign grant_tst = tst_req_i & (~wb_hit | ~last_tst);
    assign start     = (state == IDLE) & (wb_hit | tst_req_i);
    assign busy_o    = state != IDLE;
    assign wbs_ack_o = ack_q & wbs_cyc_i;
    assign wbs_dat_o = wbs_ack_o ? wb_rdata : 32'h0;
    always_comb begin
        state_nx = state == IDLE ? (start ? CMD : IDLE) :
                   state == CMD  ? DATA :
                   state == DATA ? RESP : IDLE;
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nx;
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= '0;
            sram_addr0_o  <= '0;
            sram_din0_o   <= '0;
            owner_tst     <= 1'b0;
            last_tst      <= 1'b1;
            we_q          <= 1'b0;
            ack_q         <= 1'b0;
            tst_gnt_o     <= 1'b0;
            tst_rvalid_o  <= 1'b0;
            tst_rdata_o   <= '0;
            wb_rdata      <= '0;
        end else begin
            sram_csb0_o  <= ~start;
            sram_web0_o  <= start ? ~(grant_tst ? tst_we_i : wbs_we_i) : 1'b1;
            tst_gnt_o    <= start & grant_tst;
            ack_q        <= (state == DATA) & ~owner_tst;
            tst_rvalid_o <= (state == DATA) & owner_tst;
            if (start) begin
                sram_wmask0_o <= grant_tst ? tst_wmask_i : wbs_sel_i;
                sram_addr0_o  <= grant_tst ? tst_addr_i : wbs_adr_i[ADDR_W+1:2];
                sram_din0_o   <= grant_tst ? tst_wdata_i : wbs_dat_i;
                we_q          <= grant_tst ? tst_we_i : wbs_we_i;
                owner_tst     <= grant_tst;
                last_tst      <= grant_tst;
            end
            if (state == DATA && !owner_tst) wb_rdata <= we_q ? 32'h0 : sram_dout0_i;
            if (state == DATA && owner_tst && !we_q) tst_rdata_o <= sram_dout0_i;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of sram_port_arbiter against a behavioural SRAM
module tb_sram_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, mem_clr = 1'b1;
    logic        cyc = 0, stb = 0, we = 0, ack;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat = 0, dat_o;
    logic        treq = 0, twe = 0, gnt, rvalid, csb, web, busy;
    logic [3:0]  tmask = 0, wmask;
    logic [7:0]  taddr = 0, addr;
    logic [31:0] twdata = 0, rdata, din, dout;
    logic [31:0] mem [256];
    int vectors = 0, miscompares = 0;

    sram_port_arbiter dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .tst_req_i(treq), .tst_we_i(twe), .tst_wmask_i(tmask), .tst_addr_i(taddr),
        .tst_wdata_i(twdata), .tst_gnt_o(gnt), .tst_rvalid_o(rvalid), .tst_rdata_o(rdata),
        .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask), .sram_addr0_o(addr),
        .sram_din0_o(din), .sram_dout0_i(dout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            dout <= 32'h0;
        end else if (!csb) begin
            if (!web) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
            end else dout <= mem[addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [7:0] ea, input logic [31:0] ed);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        chk("wb_busy_c0", {31'h0, busy}, 0);
        nxt();
        chk("wb_csb_c1", {31'h0, csb}, 0);
        chk("wb_web_c1", {31'h0, web}, {31'h0, ~w});
        chk("wb_addr_c1", {24'h0, addr}, {24'h0, ea});
        if (w) begin
            chk("wb_din_c1", din, d);
            chk("wb_wmask_c1", {28'h0, wmask}, {28'h0, s});
        end
        nxt();
        chk("wb_csb_c2", {31'h0, csb}, 1);
        chk("wb_ack_c2", {31'h0, ack}, 0);
        nxt();
        chk("wb_ack_c3", {31'h0, ack}, 1);
        chk("wb_dat_c3", dat_o, ed);
        cyc = 0; stb = 0; we = 0;
        nxt();
        chk("wb_ack_c4", {31'h0, ack}, 0);
        chk("wb_busy_c4", {31'h0, busy}, 0);
        chk("wb_dat_c4", dat_o, 0);
    endtask

    task automatic tst_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [31:0] er);
        treq = 1; twe = w; taddr = a; twdata = d; tmask = m;
        chk("tst_gnt_c0", {31'h0, gnt}, 0);
        nxt();
        chk("tst_gnt_c1", {31'h0, gnt}, 1);
        chk("tst_csb_c1", {31'h0, csb}, 0);
        chk("tst_web_c1", {31'h0, web}, {31'h0, ~w});
        chk("tst_addr_c1", {24'h0, addr}, {24'h0, a});
        treq = 0;
        nxt();
        chk("tst_gnt_c2", {31'h0, gnt}, 0);
        chk("tst_rvalid_c2", {31'h0, rvalid}, 0);
        nxt();
        chk("tst_rvalid_c3", {31'h0, rvalid}, 1);
        chk("tst_rdata_c3", rdata, er);
        nxt();
        chk("tst_rvalid_c4", {31'h0, rvalid}, 0);
        chk("tst_rdata_hold", rdata, er);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_csb", {31'h0, csb}, 1);
        chk("rst_web", {31'h0, web}, 1);
        chk("rst_addr", {24'h0, addr}, 0);
        chk("rst_din", din, 0);
        chk("rst_wmask", {28'h0, wmask}, 0);
        chk("rst_ack", {31'h0, ack}, 0);
        chk("rst_gnt", {31'h0, gnt}, 0);
        chk("rst_rvalid", {31'h0, rvalid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_dat_o", dat_o, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1; mem_clr = 0;
        nxt();
        wb_txn(1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 8'd4, 32'h0);
        wb_txn(0, 32'h3000_0010, 32'h0, 4'h0, 8'd4, 32'hDEAD_BEEF);
        wb_txn(1, 32'h3000_0010, 32'hCAFE_F00D, 4'h3, 8'd4, 32'h0);
        wb_txn(0, 32'h3000_0010, 32'h0, 4'h0, 8'd4, 32'hDEAD_F00D);
        cyc = 1; stb = 1; adr = 32'h3000_0400;
        for (int k = 0; k < 6; k++) begin
            nxt();
            chk("miss_ack", {31'h0, ack}, 0);
            chk("miss_csb", {31'h0, csb}, 1);
            chk("miss_busy", {31'h0, busy}, 0);
        end
        cyc = 0; stb = 0;
        nxt();
        wb_txn(1, 32'h3000_03FC, 32'h1234_5678, 4'hF, 8'hFF, 32'h0);
        tst_txn(0, 8'hFF, 32'h0, 4'h0, 32'h1234_5678);
        tst_txn(1, 8'h05, 32'hAABB_CCDD, 4'hC, 32'h1234_5678);
        wb_txn(0, 32'h3000_0014, 32'h0, 4'h0, 8'd5, 32'hAABB_0000);
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0014;
        nxt();
        nxt();
        cyc = 0; stb = 0;
        nxt();
        chk("drop_ack", {31'h0, ack}, 0);
        chk("drop_busy", {31'h0, busy}, 1);
        chk("drop_dat", dat_o, 0);
        nxt();
        chk("drop_idle", {31'h0, busy}, 0);
        rst_n = 0;
        nxt();
        rst_n = 1;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000;
        treq = 1; twe = 0; taddr = 8'h01;
        for (int k = 1; k <= 16; k++) begin
            nxt();
            chk("rr_csb", {31'h0, csb}, {31'h0, k % 4 != 1});
            chk("rr_ack", {31'h0, ack}, {31'h0, k == 3 || k == 11});
            chk("rr_gnt", {31'h0, gnt}, {31'h0, k == 5 || k == 13});
            chk("rr_rvalid", {31'h0, rvalid}, {31'h0, k == 7 || k == 15});
            if (k % 4 == 1) chk("rr_addr", {24'h0, addr}, (k % 8 == 1) ? 32'h0 : 32'h1);
        end
        cyc = 0; stb = 0; treq = 0;
        nxt();
        nxt();
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_0020; dat = 32'h1111_1111; sel = 4'hF;
        nxt();
        chk("rst6_csb_c1", {31'h0, csb}, 0);
        #2 rst_n = 0;
        #1;
        chk("rst6_csb_async", {31'h0, csb}, 1);
        chk("rst6_web_async", {31'h0, web}, 1);
        chk("rst6_busy_async", {31'h0, busy}, 0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk("rst6_no_ack", {31'h0, ack}, 0);
            chk("rst6_no_rvalid", {31'h0, rvalid}, 0);
        end
        wb_txn(0, 32'h3000_0020, 32'h0, 4'h0, 8'h08, 32'h0);
        wb_txn(0, 32'h3000_0010, 32'h0, 4'h0, 8'd4, 32'hDEAD_F00D);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
